gpio_input_conditioner: RTL

Parametrised multi-channel conditioner for asynchronous board inputs (buttons, switches, header pins) ahead of the SoC GPIO inputs. Each channel is synchronised, debounced by a consecutive-sample counter, edge-detected, and latched into a sticky pending bit. Masked pending bits raise a single registered interrupt. It replaces direct raw-pin-to-gpio_in wiring in the board top level.

---
 rtl/gpio_input_conditioner.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
// Multi-channel conditioner for asynchronous board inputs. Each channel is
// synchronised, debounced by a consecutive-sample counter, edge-detected and
// latched into a sticky pending flag. Masked pending flags raise one
// registered interrupt line.
module gpio_input_conditioner #(
    parameter int                NUM_CH          = 8,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter int                CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter logic [NUM_CH-1:0] RESET_LEVEL     = {NUM_CH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     raw_i,
    input  logic                  enable_i,
    input  logic [2*NUM_CH-1:0]   edge_sel_i,
    input  logic [NUM_CH-1:0]     mask_i,
    input  logic [NUM_CH-1:0]     clear_i,
    output logic [NUM_CH-1:0]     level_o,
    output logic [NUM_CH-1:0]     rise_o,
    output logic [NUM_CH-1:0]     fall_o,
    output logic [NUM_CH-1:0]     pending_o,
    output logic                  irq_o
);

    // Debounce FSM encoding, one state bit per channel
    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    // Last count value before a new level is accepted
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;
    logic [NUM_CH-1:0]                  r_state;
    logic [NUM_CH-1:0][CNT_W-1:0]       r_cnt;
    logic [NUM_CH-1:0]                  r_level;
    logic [NUM_CH-1:0]                  r_rise;
    logic [NUM_CH-1:0]                  r_fall;
    logic [NUM_CH-1:0]                  r_pending;
    logic                               r_irq;

    logic [NUM_CH-1:0]                  w_sync;
    logic [NUM_CH-1:0]                  w_state_nxt;
    logic [NUM_CH-1:0][CNT_W-1:0]       w_cnt_nxt;
    logic [NUM_CH-1:0]                  w_level_nxt;
    logic [NUM_CH-1:0]                  w_rise_nxt;
    logic [NUM_CH-1:0]                  w_fall_nxt;
    logic [NUM_CH-1:0]                  w_evt;
    logic [NUM_CH-1:0]                  w_pending_nxt;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Metastability synchroniser: raw pins shift in at stage 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Per-channel debounce decision; a disabled block parks every FSM idle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = '0;
        w_fall_nxt  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!enable_i) begin
                w_state_nxt[k] = ST_STABLE;
                w_cnt_nxt[k]   = '0;
            end else if (r_state[k] == ST_STABLE) begin
                w_cnt_nxt[k] = '0;
                if (w_sync[k] != r_level[k]) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // No filtering: the first mismatching sample is accepted
                        w_level_nxt[k] = w_sync[k];
                        w_rise_nxt[k]  = w_sync[k];
                        w_fall_nxt[k]  = ~w_sync[k];
                    end else begin
                        w_state_nxt[k] = ST_COUNTING;
                        w_cnt_nxt[k]   = CNT_W'(1);
                    end
                end
            end else begin
                if (w_sync[k] == r_level[k]) begin
                    // Glitch shorter than the window: discard it
                    w_state_nxt[k] = ST_STABLE;
                    w_cnt_nxt[k]   = '0;
                end else if (r_cnt[k] == CNT_LAST) begin
                    w_state_nxt[k] = ST_STABLE;
                    w_cnt_nxt[k]   = '0;
                    w_level_nxt[k] = w_sync[k];
                    w_rise_nxt[k]  = w_sync[k];
                    w_fall_nxt[k]  = ~w_sync[k];
                end else begin
                    w_cnt_nxt[k] = r_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Event selection and sticky pending update; a new event beats a clear
    always_comb begin
        w_evt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_evt[k] = (w_rise_nxt[k] & edge_sel_i[2*k]) |
                       (w_fall_nxt[k] & edge_sel_i[2*k+1]);
        end
        w_pending_nxt = (r_pending & ~clear_i) | w_evt;
    end

    // Debounce state, level, edge pulses, pending flags and interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= {NUM_CH{ST_STABLE}};
            r_cnt     <= '0;
            r_level   <= RESET_LEVEL;
            r_rise    <= '0;
            r_fall    <= '0;
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_pending <= w_pending_nxt;
            r_irq     <= |(r_pending & mask_i);
        end
    end

    assign level_o   = r_level;
    assign rise_o    = r_rise;
    assign fall_o    = r_fall;
    assign pending_o = r_pending;
    assign irq_o     = r_irq;

endmodule
